// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the
// data cache (read/write) and the instruction cache (read-only).
module cache_mem_arbiter #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_address,
    input  logic [DW-1:0] d_writedata,
    output logic [DW-1:0] d_readdata,
    output logic          d_busywait,
    input  logic          i_read,
    input  logic [AW-1:0] i_address,
    output logic [DW-1:0] i_readdata,
    output logic          i_busywait,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writedata,
    input  logic [DW-1:0] mem_readdata,
    input  logic          mem_busywait
);

    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, RELEASE} state_t;

    state_t        state_q, state_d;
    logic          issued_q, issued_d;
    logic          last_i_q, last_i_d;
    logic          d_done_q, d_done_d;
    logic          i_done_q, i_done_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_writedata_q, mem_writedata_d;
    logic [DW-1:0] d_readdata_q, d_readdata_d;
    logic [DW-1:0] i_readdata_q, i_readdata_d;
    logic          d_req;
    logic          grant_d;

    assign d_req      = d_read | d_write;
    // D wins when I is idle or when I held the previous grant
    assign grant_d    = d_req & (~i_read | last_i_q);

    assign d_busywait    = d_req & ~d_done_q;
    assign i_busywait    = i_read & ~i_done_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign d_readdata    = d_readdata_q;
    assign i_readdata    = i_readdata_q;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            issued_q        <= 1'b0;
            last_i_q        <= 1'b1;
            d_done_q        <= 1'b0;
            i_done_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            d_readdata_q    <= '0;
            i_readdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            last_i_q        <= last_i_d;
            d_done_q        <= d_done_d;
            i_done_q        <= i_done_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            d_readdata_q    <= d_readdata_d;
            i_readdata_q    <= i_readdata_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        last_i_d        = last_i_q;
        d_done_d        = 1'b0;
        i_done_d        = 1'b0;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        d_readdata_d    = d_readdata_q;
        i_readdata_d    = i_readdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d         = GRANT_D;
                    last_i_d        = 1'b0;
                    mem_address_d   = d_address;
                    mem_writedata_d = d_writedata;
                    mem_write_d     = d_write;
                    mem_read_d      = ~d_write;
                end else if (i_read) begin
                    state_d         = GRANT_I;
                    last_i_d        = 1'b1;
                    mem_address_d   = i_address;
                    mem_writedata_d = '0;
                    mem_write_d     = 1'b0;
                    mem_read_d      = 1'b1;
                end
            end
            GRANT_D, GRANT_I: begin
                // First cycle ignores busywait so memory has time to raise it
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (!mem_busywait) begin
                    if (state_q == GRANT_D) begin
                        if (mem_read_q) begin
                            d_readdata_d = mem_readdata;
                        end
                        d_done_d = 1'b1;
                    end else begin
                        i_readdata_d = mem_readdata;
                        i_done_d     = 1'b1;
                    end
                    mem_read_d      = 1'b0;
                    mem_write_d     = 1'b0;
                    mem_address_d   = '0;
                    mem_writedata_d = '0;
                    issued_d        = 1'b0;
                    state_d         = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a behavioural memory, a grant
// scoreboard fed at request time, and readdata/latency checks per requester.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [DW-1:0] d_writedata = '0;
    logic [DW-1:0] d_readdata;
    logic          d_busywait;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [DW-1:0] i_readdata;
    logic          i_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;

    cache_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_readdata   (d_readdata),
        .d_busywait   (d_busywait),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_readdata   (i_readdata),
        .i_busywait   (i_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_t;

    xfer_t         exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] d_rd_exp = '0;
    logic [DW-1:0] i_rd_exp = '0;

    function automatic logic [DW-1:0] default_word(input logic [AW-1:0] a);
        return (a == 6'h2A) ? 32'hDEADBEEF : (32'hC0DE_0000 | DW'(a));
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: busy for wait_cycles after a strobe appears, then data ready
    logic [DW-1:0] mem_arr [64];
    logic          written [64];
    int unsigned   wait_cycles = 0;
    int unsigned   cnt = 0;
    logic          busy = 1'b0;
    logic          force_busy = 1'b0;
    logic [DW-1:0] rdata = '0;

    assign mem_busywait = busy | force_busy;
    assign mem_readdata = rdata;

    always @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 64; k++) written[k] <= 1'b0;
        end
        if (!(mem_read || mem_write)) begin
            busy <= 1'b0;
            cnt  <= 0;
        end else if (cnt < wait_cycles) begin
            busy <= 1'b1;
            cnt  <= cnt + 1;
        end else begin
            busy <= 1'b0;
            if (mem_read)
                rdata <= written[mem_address] ? mem_arr[mem_address] : default_word(mem_address);
            if (mem_write) begin
                mem_arr[mem_address] <= mem_writedata;
                written[mem_address] <= 1'b1;
            end
        end
    end

    // Grant monitor: every new memory transaction must match the next expected one
    logic strobe_seen = 1'b0;
    always @(negedge clock) begin
        if ((mem_read || mem_write) && !strobe_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL grant_unexpected: observed addr=%h expected no grant", mem_address);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                check("grant_addr", DW'(mem_address), DW'(e.addr));
                check("grant_write", DW'(mem_write), DW'(e.wr));
                check("grant_read", DW'(mem_read), DW'(!e.wr));
                if (e.wr) check("grant_wdata", mem_writedata, e.wdata);
            end
        end
        strobe_seen = mem_read || mem_write;
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One transfer from a single requester; lat counts edges from request to busywait low
    task automatic xfer(input bit is_i, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int lat);
        xfer_t e;
        int    n = 0;
        logic  bw;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wr ? wd : '0;
        exp_q.push_back(e);
        if (is_i) begin
            i_address = a;
            i_read    = 1'b1;
        end else begin
            d_address   = a;
            d_writedata = wd;
            d_write     = wr;
            d_read      = !wr;
        end
        do begin
            cyc();
            n++;
            if (wr && mem_write) check("wb_hold", mem_writedata, wd);
            bw = is_i ? i_busywait : d_busywait;
        end while (bw && n < 50);
        check("latency", DW'(n), DW'(lat));
        if (!wr) begin
            if (is_i) i_rd_exp = exp_rd;
            else      d_rd_exp = exp_rd;
        end
        check("d_rdata", d_readdata, d_rd_exp);
        check("i_rdata", i_readdata, i_rd_exp);
        d_read  = 1'b0;
        d_write = 1'b0;
        i_read  = 1'b0;
        cyc();
        check("idle_gap", DW'({mem_read, mem_write}), DW'(0));
    endtask

    // Both requesters re-request as soon as allowed; grants must alternate D,I,D,I
    task automatic both_rr();
        int    dn = 0;
        int    in_cnt = 0;
        int    t = 0;
        bit    d_act = 1'b0;
        bit    i_act = 1'b0;
        xfer_t e;
        for (int k = 0; k < 2; k++) begin
            e.wr = 1'b0; e.wdata = '0;
            e.addr = AW'(32 + k); exp_q.push_back(e);
            e.addr = AW'(48 + k); exp_q.push_back(e);
        end
        while ((dn < 2 || in_cnt < 2) && t < 200) begin
            if (d_act && !d_busywait) begin
                check("rr_d_rdata", d_readdata, default_word(AW'(32 + dn)));
                d_read = 1'b0; d_act = 1'b0; dn++;
            end else if (!d_act && dn < 2) begin
                d_address = AW'(32 + dn); d_read = 1'b1; d_act = 1'b1;
            end
            if (i_act && !i_busywait) begin
                check("rr_i_rdata", i_readdata, default_word(AW'(48 + in_cnt)));
                i_read = 1'b0; i_act = 1'b0; in_cnt++;
            end else if (!i_act && in_cnt < 2) begin
                i_address = AW'(48 + in_cnt); i_read = 1'b1; i_act = 1'b1;
            end
            cyc();
            t++;
        end
        check("rr_count", DW'(dn + in_cnt), DW'(4));
        d_read = 1'b0;
        i_read = 1'b0;
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        cyc(); cyc();
        check("rst_mem_read", DW'(mem_read), DW'(0));
        check("rst_mem_write", DW'(mem_write), DW'(0));
        check("rst_mem_addr", DW'(mem_address), DW'(0));
        check("rst_mem_wdata", mem_writedata, DW'(0));
        check("rst_d_rdata", d_readdata, DW'(0));
        check("rst_i_rdata", i_readdata, DW'(0));
        check("rst_d_busy", DW'(d_busywait), DW'(0));
        check("rst_i_busy", DW'(i_busywait), DW'(0));
        reset = 1'b1;
        cyc();

        // Reset while GRANT_D is stalled on a busy memory
        begin
            xfer_t e;
            e.wr = 1'b0; e.addr = 6'h05; e.wdata = '0;
            exp_q.push_back(e);
        end
        force_busy = 1'b1;
        d_address  = 6'h05;
        d_read     = 1'b1;
        cyc(); cyc(); cyc();
        check("pre_rst_mem_read", DW'(mem_read), DW'(1));
        check("pre_rst_d_busy", DW'(d_busywait), DW'(1));
        reset     = 1'b0;
        i_address = 6'h07;
        i_read    = 1'b1;
        cyc(); cyc();
        check("midrst_mem_read", DW'(mem_read), DW'(0));
        check("midrst_mem_write", DW'(mem_write), DW'(0));
        check("midrst_mem_addr", DW'(mem_address), DW'(0));
        check("midrst_d_busy", DW'(d_busywait), DW'(1));
        check("midrst_i_busy", DW'(i_busywait), DW'(1));
        d_read     = 1'b0;
        i_read     = 1'b0;
        force_busy = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("postrst_idle", DW'({mem_read, mem_write}), DW'(0));

        // D read, memory busy 5 cycles
        wait_cycles = 5;
        xfer(1'b0, 1'b0, 6'h2A, '0, 32'hDEADBEEF, 8);

        // D write-back, memory busy 2 cycles; d_readdata must hold
        wait_cycles = 2;
        xfer(1'b0, 1'b1, 6'h11, 32'h12345678, '0, 5);

        // Zero-wait I reads back to back: grant N, done N+2, next grant N+4
        wait_cycles = 0;
        xfer(1'b1, 1'b0, 6'h11, '0, 32'h12345678, 3);
        xfer(1'b1, 1'b0, 6'h2A, '0, 32'hDEADBEEF, 3);

        // Fresh reset, then both request together continuously
        reset = 1'b0;
        cyc();
        reset    = 1'b1;
        d_rd_exp = '0;
        i_rd_exp = '0;
        check("rst2_d_rdata", d_readdata, d_rd_exp);
        check("rst2_i_rdata", i_readdata, i_rd_exp);
        wait_cycles = 1;
        both_rr();

        check("sb_drained", DW'(exp_q.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
